// File: rtl/mod45_pkg.sv
// mod45_pkg: shared definitions for the mod-4/mod-5 sequence tracker.
//   state_t   - tracker FSM states (HUNT, PH4, PH5)
//   PH4_LAST  - last count value of a mod-4 phase
//   PH5_LAST  - last count value of a mod-5 phase (also the frame marker)
//   FRAME_LEN - samples per complete 4+5 frame
package mod45_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        PH4  = 2'd1,
        PH5  = 2'd2
    } state_t;

    localparam logic [2:0] PH4_LAST  = 3'd3;
    localparam logic [2:0] PH5_LAST  = 3'd4;
    localparam int         FRAME_LEN = 9;

endpackage

// File: rtl/mod45_sat_cnt.sv
// mod45_sat_cnt: saturating up-counter with synchronous clear.
// Parameters:
//   W   - counter width
//   MAX - value at which the counter stops incrementing
// Ports:
//   clk - clock
//   clr - synchronous clear (priority over inc)
//   inc - increment request
//   cnt - current count
module mod45_sat_cnt #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != MAX)) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/mod45_seq_tracker.sv
// mod45_seq_tracker: locks onto the 9-sample frame 0,1,2,3,0,1,2,3,4 produced
// by an alternating mod-4/mod-5 counter and reports phase wraps, completed
// frames, lock status and sequence errors. All outputs are registered.
//
// Optional build macro: MOD45_TRK_ERR_CNT_EN builds the saturating err_cnt
// register; without it err_cnt is constant 0.
//
// Parameters:
//   LOCK_N  - consecutive good frames before locked asserts (1..15)
//   FRAME_W - width of frame_cnt
//   ERR_W   - width of err_cnt
// Ports:
//   clk        - clock (posedge)
//   rst        - synchronous active-high reset
//   count_in   - sampled counter value
//   in_valid   - count_in is sampled only when high
//   wrap4      - pulse: mod-4 phase completed
//   wrap5      - pulse: mod-5 phase completed
//   frame_done - pulse: frame completed (same cycle as wrap5)
//   frame_cnt  - completed frames since reset (wraps)
//   locked     - level: LOCK_N consecutive good frames seen
//   err        - pulse: sequence mismatch
//   err_cnt    - saturating mismatch count
module mod45_seq_tracker
    import mod45_pkg::*;
#(
    parameter int LOCK_N  = 2,
    parameter int FRAME_W = 8,
    parameter int ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         count_in,
    input  logic               in_valid,
    output logic               wrap4,
    output logic               wrap5,
    output logic               frame_done,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               locked,
    output logic               err,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam logic [3:0] LOCK_MAX = 4'(LOCK_N);

    state_t             state_reg, state_next;
    logic [2:0]         expect_reg, expect_next;
    logic               wrap4_reg, wrap4_next;
    logic               wrap5_reg, wrap5_next;
    logic               err_reg, err_next;
    logic [FRAME_W-1:0] frame_cnt_reg;
    logic               locked_reg;
    logic [3:0]         good_cnt;

    // Next-state and event decode. Events only arise on valid samples.
    always_comb begin
        state_next  = state_reg;
        expect_next = expect_reg;
        wrap4_next  = 1'b0;
        wrap5_next  = 1'b0;
        err_next    = 1'b0;
        if (in_valid) begin
            case (state_reg)
                HUNT: begin
                    // Only a 4 marks a frame boundary unambiguously.
                    if (count_in == PH5_LAST) begin
                        state_next  = PH4;
                        expect_next = 3'd0;
                    end
                end
                PH4: begin
                    if (count_in != expect_reg) begin
                        err_next    = 1'b1;
                        state_next  = HUNT;
                        expect_next = 3'd0;
                    end else if (expect_reg == PH4_LAST) begin
                        wrap4_next  = 1'b1;
                        state_next  = PH5;
                        expect_next = 3'd0;
                    end else begin
                        expect_next = expect_reg + 3'd1;
                    end
                end
                PH5: begin
                    if (count_in != expect_reg) begin
                        // A mismatching 4 lands in HUNT and is not taken as a marker.
                        err_next    = 1'b1;
                        state_next  = HUNT;
                        expect_next = 3'd0;
                    end else if (expect_reg == PH5_LAST) begin
                        wrap5_next  = 1'b1;
                        state_next  = PH4;
                        expect_next = 3'd0;
                    end else begin
                        expect_next = expect_reg + 3'd1;
                    end
                end
                default: begin
                    state_next  = HUNT;
                    expect_next = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= HUNT;
            expect_reg    <= 3'd0;
            wrap4_reg     <= 1'b0;
            wrap5_reg     <= 1'b0;
            err_reg       <= 1'b0;
            frame_cnt_reg <= '0;
            locked_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            expect_reg <= expect_next;
            wrap4_reg  <= wrap4_next;
            wrap5_reg  <= wrap5_next;
            err_reg    <= err_next;
            if (wrap5_next) begin
                frame_cnt_reg <= frame_cnt_reg + FRAME_W'(1);
            end
            // Lock asserts in the same update in which the good-frame
            // counter reaches LOCK_N.
            if (err_next) begin
                locked_reg <= 1'b0;
            end else if (wrap5_next && (good_cnt >= (LOCK_MAX - 4'd1))) begin
                locked_reg <= 1'b1;
            end
        end
    end

    mod45_sat_cnt #(
        .W   (4),
        .MAX (LOCK_MAX)
    ) u_good_cnt (
        .clk (clk),
        .clr (rst | err_next),
        .inc (wrap5_next),
        .cnt (good_cnt)
    );

`ifdef MOD45_TRK_ERR_CNT_EN
    mod45_sat_cnt #(
        .W   (ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .clr (rst),
        .inc (err_next),
        .cnt (err_cnt)
    );
`else
    assign err_cnt = '0;
`endif

    assign wrap4      = wrap4_reg;
    assign wrap5      = wrap5_reg;
    assign frame_done = wrap5_reg;
    assign frame_cnt  = frame_cnt_reg;
    assign locked     = locked_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_mod45_seq_tracker.sv
// Testbench for mod45_seq_tracker: directed stimulus, a frame-position model
// checked every cycle, and literal checkpoints at key points of the sequence.
module tb_mod45_seq_tracker;
    import mod45_pkg::*;

    localparam int LOCK_N  = 2;
    localparam int FRAME_W = 8;
    localparam int ERR_W   = 2;
    localparam int ERR_MAX = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [2:0]         count_in = 3'd0;
    logic               in_valid = 1'b0;
    logic               wrap4, wrap5, frame_done, locked, err;
    logic [FRAME_W-1:0] frame_cnt;
    logic [ERR_W-1:0]   err_cnt;

    mod45_seq_tracker #(
        .LOCK_N  (LOCK_N),
        .FRAME_W (FRAME_W),
        .ERR_W   (ERR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .in_valid   (in_valid),
        .wrap4      (wrap4),
        .wrap5      (wrap5),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .locked     (locked),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Model: position within the frame (-1 while hunting).
    int frame_seq [FRAME_LEN] = '{0, 1, 2, 3, 0, 1, 2, 3, 4};
    int m_pos = -1;
    int m_good = 0;
    int m_fcnt = 0;
    int m_errc = 0;
    int m_locked = 0;
    int m_w4 = 0, m_w5 = 0, m_err = 0;

`ifdef MOD45_TRK_ERR_CNT_EN
    localparam bit ERR_CNT_BUILT = 1'b1;
`else
    localparam bit ERR_CNT_BUILT = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic model_update(input bit r, input bit v, input int val);
        m_w4 = 0; m_w5 = 0; m_err = 0;
        if (r) begin
            m_pos = -1; m_good = 0; m_fcnt = 0; m_errc = 0; m_locked = 0;
        end else if (v) begin
            if (m_pos < 0) begin
                if (val == 4) m_pos = 0;
            end else if (val == frame_seq[m_pos]) begin
                if (m_pos == 3) m_w4 = 1;
                if (m_pos == FRAME_LEN - 1) begin
                    m_w5 = 1;
                    m_fcnt = (m_fcnt + 1) % (1 << FRAME_W);
                    if (m_good < LOCK_N) m_good++;
                    if (m_good == LOCK_N) m_locked = 1;
                end
                m_pos = (m_pos + 1) % FRAME_LEN;
            end else begin
                m_err = 1;
                if (ERR_CNT_BUILT && m_errc < ERR_MAX) m_errc++;
                m_good = 0;
                m_locked = 0;
                m_pos = -1;
            end
        end
    endtask

    // Drive one cycle, then advance the model with what the DUT sampled.
    task automatic step(input bit r, input bit v, input int val);
        rst = r;
        in_valid = v;
        count_in = 3'(val);
        @(posedge clk);
        model_update(r, v, val);
        #1;
        $display("txn rst=%0d valid=%0d in=%0d -> w4=%0d w5=%0d fd=%0d err=%0d fcnt=%0d lock=%0d ecnt=%0d",
                 r, v, val, wrap4, wrap5, frame_done, err, frame_cnt, locked, err_cnt);
    endtask

    task automatic send(input int val);
        step(1'b0, 1'b1, val);
    endtask

    task automatic send_frame();
        for (int i = 0; i < FRAME_LEN; i++) send(frame_seq[i]);
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("wrap4", int'(wrap4), m_w4);
            chk("wrap5", int'(wrap5), m_w5);
            chk("frame_done", int'(frame_done), m_w5);
            chk("err", int'(err), m_err);
            chk("frame_cnt", int'(frame_cnt), m_fcnt);
            chk("locked", int'(locked), m_locked);
            chk("err_cnt", int'(err_cnt), m_errc);
        end
    end

    int e1, e3;

    initial begin
        e1 = ERR_CNT_BUILT ? 1 : 0;
        e3 = ERR_CNT_BUILT ? 3 : 0;

        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 4);
        chk_en = 1'b1;
        chk("reset_outputs", {29'd0, wrap4, wrap5, err} | int'(frame_cnt) | int'(locked) | int'(err_cnt), 0);

        // Clean lock: hunt values ignored until the first 4.
        send(0); send(1); send(2); send(3);
        chk("hunt_no_err", int'(err), 0);
        send(4);
        for (int i = 0; i < FRAME_LEN - 1; i++) send(frame_seq[i]);
        chk("no_frame_before_10", int'(frame_done), 0);
        send(4);
        chk("first_frame_done", int'(frame_done), 1);
        chk("first_frame_cnt", int'(frame_cnt), 1);
        chk("not_locked_1", int'(locked), 0);
        send_frame();
        chk("locked_after_2", int'(locked), 1);
        chk("frame_cnt_2", int'(frame_cnt), 2);

        // Injected error: PH5 value 2 replaced by 3.
        send(0); send(1); send(2); send(3); send(0); send(1);
        send(3);
        chk("inj_err_pulse", int'(err), 1);
        chk("inj_err_cnt", int'(err_cnt), e1);
        chk("inj_unlocked", int'(locked), 0);
        send(3);
        chk("err_single_pulse", int'(err), 0);
        send(4);
        send_frame();
        chk("relock_not_yet", int'(locked), 0);
        send_frame();
        chk("relock", int'(locked), 1);
        chk("frame_cnt_4", int'(frame_cnt), 4);

        // Valid gaps mid-PH4 with count_in at 7.
        send(0); send(1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 7);
        chk("gap_no_err", int'(err), 0);
        send(2); send(3); send(0); send(1); send(2); send(3); send(4);
        chk("gap_frame_done", int'(frame_done), 1);
        chk("frame_cnt_5", int'(frame_cnt), 5);

        // Reset mid-frame at PH5 expect=2.
        send(0); send(1); send(2); send(3); send(0); send(1);
        step(1'b1, 1'b1, 2);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_pulses", {29'd0, wrap4, wrap5, err}, 0);
        send(0); send(1); send(2); send(3);
        chk("rst_hunt_no_wrap4", int'(wrap4), 0);

        // Illegal values in PH4.
        send(4); send(0); send(1);
        send(5);
        chk("illegal_err", int'(err), 1);
        send(6);
        chk("illegal_ignored_6", int'(err), 0);
        send(7);
        chk("illegal_ignored_7", int'(err), 0);
        chk("illegal_err_cnt", int'(err_cnt), e1);

        // Saturation: four more marker+mismatch pairs.
        for (int i = 0; i < 4; i++) begin
            send(4);
            send(5);
        end
        chk("sat_err_cnt", int'(err_cnt), e3);

        step(1'b0, 1'b0, 0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
